spo_response_compactor: RTL and testbench

// - Receive-side companion to a buffer/splitter-balanced combinational benchmark netlist (ISCAS-style, SPO_3 class).
// - Tracks every input vector launched into the DUT and waits the balanced pipeline depth LAT before sampling the DUT outputs.
// - Compacts each sampled output word into a MISR signature.
// - Reports done and the final signature after NUM vectors, so the harness compares one word against a golden value.

---
 rtl/spo_response_compactor_pkg.sv | 18 +
 rtl/spo_response_compactor_if.sv | 26 ++
 rtl/spo_response_compactor_valid_delay.sv | 28 ++
 rtl/spo_response_compactor.sv | 97 +++++++++
 tb/tb_spo_response_compactor.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/spo_response_compactor_pkg.sv
// Shared harness definitions: FSM state encoding, default MISR constants and
// the MISR step function also used by the stimulus-side generator.
package spo_harness_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int MISR_W = 16;
    typedef logic [MISR_W-1:0] misr_t;

    localparam misr_t POLY_DEFAULT = 16'h1021;
    localparam misr_t SEED_DEFAULT = 16'h0000;

    // One MISR step: shift left, fold the outgoing MSB back through the taps, xor in data.
    function automatic misr_t misr_next(input misr_t sig, input misr_t data, input misr_t poly);
        return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/spo_response_compactor_if.sv
// Harness-side bundle between the stimulus driver and the response compactor.
interface spo_response_compactor_if #(
    parameter int OUT_W = 4,
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             launch;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] sample_cnt;
    logic             overrun;

    modport master (
        output start, num_vec, launch, dut_out,
        input  busy, done, signature, sample_cnt, overrun
    );

    modport slave (
        input  start, num_vec, launch, dut_out,
        output busy, done, signature, sample_cnt, overrun
    );
endinterface

// File: rtl/spo_response_compactor_valid_delay.sv
// LAT-deep shift register of launch valids; its output marks the cycle in which
// the DUT response to that launch is present on dut_out.
module spo_valid_delay #(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    logic [LAT-1:0] pipe;

    // NOTE: the valid pipe is control state, so it is reset; a reset here is what
    // discards in-flight launches when a run is aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift from the old values.
            pipe[0] <= in;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out = pipe[LAT-1];
endmodule

// File: rtl/spo_response_compactor.sv
// Receive-side compactor: counts launches, samples dut_out LAT clocks after each
// accepted launch, folds samples into a MISR and pulses done after num_vec samples.
module spo_response_compactor
    import spo_harness_pkg::*;
#(
    parameter int          OUT_W = 4,
    parameter int          SIG_W = MISR_W,
    parameter logic [SIG_W-1:0] POLY = POLY_DEFAULT,
    parameter logic [SIG_W-1:0] SEED = SEED_DEFAULT,
    parameter int          LAT   = 3,
    parameter int          CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    spo_response_compactor_if.slave bus
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] launch_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic [SIG_W-1:0] sig;
    logic [OUT_W-1:0] sample_word;
    logic             overrun;
    logic             start_ok;
    logic             launch_ok;
    logic             last_launch;
    logic             sample;
    logic             busy;
    logic             done;

    assign start_ok    = (state == IDLE) && bus.start;
    assign launch_ok   = (state == RUN) && bus.launch;
    assign last_launch = launch_ok && ((launch_cnt + CNT_W'(1)) == num_lat);
    assign sample_word = bus.dut_out;

    spo_valid_delay #(.LAT(LAT)) u_valid_delay (
        .clk (clk),
        .rst (rst),
        .in  (launch_ok),
        .out (sample)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: default assignment first so every path drives state_nx (no latch).
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = (bus.num_vec == '0) ? DONE : RUN;
            RUN:     if (last_launch) state_nx = DRAIN;
            DRAIN:   if (sample_cnt == num_lat) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat    <= '0;
            launch_cnt <= '0;
            sample_cnt <= '0;
            sig        <= SEED;
            overrun    <= 1'b0;
        end else begin
            // The pipe is always empty in IDLE, so a sample never coincides with a start.
            if (start_ok) begin
                num_lat    <= bus.num_vec;
                launch_cnt <= '0;
                sample_cnt <= '0;
                sig        <= SEED;
            end else begin
                if (launch_ok) launch_cnt <= launch_cnt + CNT_W'(1);
                if (sample) begin
                    sig        <= misr_next(sig, misr_t'(sample_word), misr_t'(POLY));
                    sample_cnt <= sample_cnt + CNT_W'(1);
                end
            end
            // A stray launch on the same edge as the clearing start still leaves overrun set.
            if (bus.launch && (state != RUN)) overrun <= 1'b1;
            else if (start_ok)                 overrun <= 1'b0;
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.signature  = sig;
    assign bus.sample_cnt = sample_cnt;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_spo_response_compactor.sv
// Directed bench for spo_response_compactor: per-cycle vector table plus
// hand-written sequences for feedback, reset abort and maximum run length.
module tb_spo_response_compactor;
    localparam int LAT   = 3;
    localparam int NVMAX = 65535;

    typedef struct {
        logic        start;
        logic [15:0] nv;
        logic        launch;
        logic [3:0]  dout;
        logic        busy;
        logic        done;
        logic [15:0] sig;
        logic [15:0] cnt;
        logic        ovr;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t tbl[$];

    spo_response_compactor_if #(.OUT_W(4), .SIG_W(16), .CNT_W(16)) bus  ();
    spo_response_compactor_if #(.OUT_W(4), .SIG_W(16), .CNT_W(16)) bus2 ();

    spo_response_compactor #(.LAT(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    spo_response_compactor #(.LAT(LAT), .SEED(16'h8000)) u_dut_seed (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] tb_misr(input logic [15:0] s, input logic [3:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic s, input logic [15:0] nv, input logic l, input logic [3:0] d,
                       input logic b, input logic dn, input logic [15:0] sg,
                       input logic [15:0] c, input logic o);
        vec_t v;
        v.start = s; v.nv = nv; v.launch = l; v.dout = d;
        v.busy = b; v.done = dn; v.sig = sg; v.cnt = c; v.ovr = o;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] exp_sig;
        logic        got_done;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.start = 1'b0;  bus.num_vec = '0;  bus.launch = 1'b0;  bus.dut_out = '0;
        bus2.start = 1'b0; bus2.num_vec = '0; bus2.launch = 1'b0; bus2.dut_out = '0;

        // Columns: start nv launch dout | busy done sig cnt overrun (outputs seen in that cycle)
        row(1, 1, 0, 4'hF, 0, 0, 16'h0000, 0, 0);  // single vector
        row(0, 0, 1, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hA, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hF, 1, 0, 16'h000A, 1, 0);
        row(0, 0, 0, 4'hF, 0, 1, 16'h000A, 1, 0);
        row(0, 0, 0, 4'hF, 0, 0, 16'h000A, 1, 0);
        row(1, 2, 0, 4'hF, 0, 0, 16'h000A, 1, 0);  // two back-to-back vectors
        row(0, 0, 1, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 1, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hA, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 0, 4'h5, 1, 0, 16'h000A, 1, 0);
        row(0, 0, 0, 4'hF, 1, 0, 16'h0011, 2, 0);
        row(0, 0, 0, 4'hF, 0, 1, 16'h0011, 2, 0);
        row(0, 0, 0, 4'hF, 0, 0, 16'h0011, 2, 0);
        row(1, 0, 0, 4'hF, 0, 0, 16'h0011, 2, 0);  // num_vec = 0
        row(0, 0, 0, 4'hF, 0, 1, 16'h0000, 0, 0);
        row(0, 0, 0, 4'hF, 0, 0, 16'h0000, 0, 0);
        row(0, 0, 1, 4'hF, 0, 0, 16'h0000, 0, 0);  // launch in IDLE
        row(1, 1, 0, 4'hF, 0, 0, 16'h0000, 0, 1);
        row(0, 0, 1, 4'hF, 1, 0, 16'h0000, 0, 0);
        row(0, 0, 1, 4'hF, 1, 0, 16'h0000, 0, 0);  // extra launch in DRAIN
        row(0, 0, 0, 4'hF, 1, 0, 16'h0000, 0, 1);
        row(0, 0, 0, 4'h3, 1, 0, 16'h0000, 0, 1);
        row(0, 0, 0, 4'hF, 1, 0, 16'h0003, 1, 1);
        row(0, 0, 0, 4'hF, 0, 1, 16'h0003, 1, 1);
        row(1, 1, 1, 4'hF, 0, 0, 16'h0003, 1, 1);  // start + launch in IDLE
        row(0, 0, 0, 4'hF, 1, 0, 16'h0000, 0, 1);
        row(0, 0, 1, 4'hF, 1, 0, 16'h0000, 0, 1);
        row(1, 5, 0, 4'hF, 1, 0, 16'h0000, 0, 1);  // start in DRAIN ignored
        row(0, 0, 0, 4'hF, 1, 0, 16'h0000, 0, 1);
        row(0, 0, 0, 4'hC, 1, 0, 16'h0000, 0, 1);
        row(0, 0, 0, 4'hF, 1, 0, 16'h000C, 1, 1);
        row(1, 7, 0, 4'hF, 0, 1, 16'h000C, 1, 1);  // start in DONE ignored
        row(0, 0, 0, 4'hF, 0, 0, 16'h000C, 1, 1);
        row(0, 0, 0, 4'hF, 0, 0, 16'h000C, 1, 1);

        repeat (3) cyc();
        rst = 1'b0;
        check("seed_dut reset signature", 32'(bus2.signature), 32'h8000);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.start   = tbl[i].start;
            bus.num_vec = tbl[i].nv;
            bus.launch  = tbl[i].launch;
            bus.dut_out = tbl[i].dout;
            check($sformatf("row%0d busy", i),      32'(bus.busy),       32'(tbl[i].busy));
            check($sformatf("row%0d done", i),      32'(bus.done),       32'(tbl[i].done));
            check($sformatf("row%0d signature", i), 32'(bus.signature),  32'(tbl[i].sig));
            check($sformatf("row%0d sample_cnt", i), 32'(bus.sample_cnt), 32'(tbl[i].cnt));
            check($sformatf("row%0d overrun", i),   32'(bus.overrun),    32'(tbl[i].ovr));
            cyc();
        end
        bus.start = 1'b0; bus.launch = 1'b0; bus.num_vec = '0;

        // Feedback path: SEED=8000, single sample of 0 must fold in POLY.
        bus2.start = 1'b1; bus2.num_vec = 16'd1; cyc();
        bus2.start = 1'b0; bus2.launch = 1'b1; bus2.dut_out = 4'hF; cyc();
        bus2.launch = 1'b0; cyc();
        cyc();
        bus2.dut_out = 4'h0; cyc();
        bus2.dut_out = 4'hF;
        check("feedback signature", 32'(bus2.signature), 32'h1021);
        check("feedback sample_cnt", 32'(bus2.sample_cnt), 32'd1);
        cyc();
        check("feedback done", 32'(bus2.done), 32'd1);
        cyc();
        check("feedback done falls", 32'(bus2.done), 32'd0);

        // Reset mid-run with two samples still in flight.
        bus.start = 1'b1; bus.num_vec = 16'd4; bus.launch = 1'b1; cyc();
        bus.start = 1'b0; cyc();
        cyc();
        cyc();
        bus.launch = 1'b0; bus.dut_out = 4'h9; cyc();
        bus.dut_out = 4'hF;
        check("abort pre-reset signature", 32'(bus.signature), 32'h0009);
        check("abort pre-reset overrun", 32'(bus.overrun), 32'd1);
        check("abort pre-reset busy", 32'(bus.busy), 32'd1);
        rst = 1'b1; cyc();
        rst = 1'b0;
        check("abort reset busy", 32'(bus.busy), 32'd0);
        check("abort reset signature", 32'(bus.signature), 32'h0000);
        check("abort reset sample_cnt", 32'(bus.sample_cnt), 32'd0);
        check("abort reset overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            check($sformatf("abort idle%0d done", i), 32'(bus.done), 32'd0);
            check($sformatf("abort idle%0d sample_cnt", i), 32'(bus.sample_cnt), 32'd0);
            cyc();
        end
        bus.start = 1'b1; bus.num_vec = 16'd1; cyc();
        bus.start = 1'b0; bus.launch = 1'b1; cyc();
        bus.launch = 1'b0; cyc();
        cyc();
        bus.dut_out = 4'h6; cyc();
        bus.dut_out = 4'hF;
        check("post-reset signature", 32'(bus.signature), 32'h0006);
        cyc();
        check("post-reset done", 32'(bus.done), 32'd1);
        cyc();

        // Longest run: num_vec = 2^16-1, one launch per cycle, varying dut_out.
        exp_sig = 16'h0000;
        bus.start = 1'b1; bus.num_vec = 16'(NVMAX); cyc();
        bus.start = 1'b0;
        for (int k = 0; k < NVMAX + LAT; k++) begin
            bus.launch  = (k < NVMAX);
            bus.dut_out = 4'(k);
            if (k >= LAT) exp_sig = tb_misr(exp_sig, 4'(k));
            cyc();
        end
        bus.launch = 1'b0;
        check("maxrun signature", 32'(bus.signature), 32'(exp_sig));
        check("maxrun sample_cnt", 32'(bus.sample_cnt), 32'(NVMAX));
        check("maxrun overrun", 32'(bus.overrun), 32'd0);
        got_done = 1'b0;
        for (int n = 0; n < 8 && !got_done; n++) begin
            if (bus.done) got_done = 1'b1;
            else cyc();
        end
        check("maxrun done within budget", 32'(got_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
